// File: rtl/up_copy_engine_if.sv
// Memory port of the copy engine: PULPino-style req/gnt/rvalid with a single
// outstanding transaction. The engine is the master, the memory the slave.
interface up_copy_engine_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic                  mem_we_o;
   logic [3:0]            mem_be_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/up_copy_engine.sv
// Word-by-word memory-to-memory copy engine behind the user-plugin register block.
// Read a word, write it back, repeat; sticky completion flag gated onto the irq line.
module up_copy_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SIZE_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [SIZE_WIDTH-1:0] size_i,
   input  logic                  int_en_i,
   input  logic                  trigger_i,
   input  logic                  clr_int_i,
   output logic                  busy_o,
   output logic                  int_pending_o,
   output logic                  int_o,
   up_copy_engine_if.master      mem
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [SIZE_WIDTH-2:0] words_q;
   logic [SIZE_WIDTH-2:0] words_init;
   logic [1:0]            tail_q;
   logic [DATA_WIDTH-1:0] rbuf_q;
   logic                  pend_q;
   logic                  last_word;
   logic [3:0]            wr_be;

   // ceil(size/4) without a wider intermediate: whole words plus one if any tail bytes
   assign words_init = {1'b0, size_i[SIZE_WIDTH-1:2]} + (SIZE_WIDTH-1)'(|size_i[1:0]);
   assign last_word  = (words_q == (SIZE_WIDTH-1)'(1));
   assign wr_be      = (last_word && tail_q != 2'd0) ? ~(4'b1111 << tail_q) : 4'hF;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         words_q <= '0;
         tail_q  <= '0;
         rbuf_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (trigger_i) begin
               src_q   <= src_addr_i & ~ADDR_WIDTH'(3);
               dst_q   <= dst_addr_i & ~ADDR_WIDTH'(3);
               words_q <= words_init;
               tail_q  <= size_i[1:0];
            end
            RD_WAIT: if (mem.mem_rvalid_i) rbuf_q <= mem.mem_rdata_i;
            WR_WAIT: if (mem.mem_rvalid_i) begin
               src_q   <= src_q + ADDR_WIDTH'(4);
               dst_q   <= dst_q + ADDR_WIDTH'(4);
               words_q <= words_q - (SIZE_WIDTH-1)'(1);
            end
            default: ;
         endcase
         // completion has priority over a clear landing in the same cycle
         if (state_q == DONE)  pend_q <= 1'b1;
         else if (clr_int_i)   pend_q <= 1'b0;
      end
   end

   always_comb begin
      state_d         = state_q;
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_be_o    = 4'h0;
      mem.mem_addr_o  = '0;
      mem.mem_wdata_o = '0;
      case (state_q)
         IDLE:    if (trigger_i) state_d = (size_i == '0) ? DONE : RD_REQ;
         RD_REQ: begin
            mem.mem_req_o  = 1'b1;
            mem.mem_be_o   = 4'hF;
            mem.mem_addr_o = src_q;
            if (mem.mem_gnt_i) state_d = RD_WAIT;
         end
         RD_WAIT: if (mem.mem_rvalid_i) state_d = WR_REQ;
         WR_REQ: begin
            mem.mem_req_o   = 1'b1;
            mem.mem_we_o    = 1'b1;
            mem.mem_be_o    = wr_be;
            mem.mem_addr_o  = dst_q;
            mem.mem_wdata_o = rbuf_q;
            if (mem.mem_gnt_i) state_d = WR_WAIT;
         end
         WR_WAIT: if (mem.mem_rvalid_i) state_d = last_word ? DONE : RD_REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o        = (state_q != IDLE);
   assign int_pending_o = pend_q;
   assign int_o         = pend_q & int_en_i;

endmodule

// File: tb/tb_up_copy_engine.sv
// Directed + randomized bench for up_copy_engine: behavioural memory with
// programmable gnt/rvalid delays and a byte-level copy model.
module tb_up_copy_engine;
   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] src_addr = '0, dst_addr = '0;
   logic [15:0] size = '0;
   logic        int_en = 1'b0, trigger = 1'b0, clr_int = 1'b0;
   logic        busy, int_pending, int_irq;

   up_copy_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   up_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .src_addr_i(src_addr), .dst_addr_i(dst_addr), .size_i(size),
      .int_en_i(int_en), .trigger_i(trigger), .clr_int_i(clr_int),
      .busy_o(busy), .int_pending_o(int_pending), .int_o(int_irq),
      .mem(bus)
   );

   always #5 ACLK = ~ACLK;

   int nchk = 0, nerr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 16 KB memory, aliased modulo its size so wrapped addresses stay legal
   logic [31:0] mem  [0:4095];
   logic [31:0] snap [0:4095];
   logic [31:0] expm [0:4095];

   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] data;} txn_t;
   txn_t log_q[$];

   int   gdly = 0, rdly = 0, g_c = 0, rv_c = 0;
   bit   pend = 0, stray = 0;
   logic [31:0] rdq, p_addr, p_wdata;
   logic [3:0]  p_be;
   logic        p_we;

   always @(negedge ACLK) begin
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = stray;
      if (ARESET) begin
         pend = 0;
         g_c  = 0;
      end else if (pend) begin
         if (rv_c == 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rdq;
            pend = 0;
         end else rv_c--;
      end else if (bus.mem_req_o) begin
         if (g_c > 0) begin
            chk("stall_addr",  bus.mem_addr_o,  p_addr);
            chk("stall_wdata", bus.mem_wdata_o, p_wdata);
            chk("stall_we",    bus.mem_we_o,    p_we);
            chk("stall_be",    bus.mem_be_o,    p_be);
         end
         p_addr = bus.mem_addr_o; p_wdata = bus.mem_wdata_o;
         p_we   = bus.mem_we_o;   p_be    = bus.mem_be_o;
         if (g_c < gdly) g_c++;
         else begin
            bus.mem_gnt_i = 1'b1;
            g_c  = 0;
            pend = 1;
            rv_c = rdly;
            log_q.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o});
            if (bus.mem_we_o) begin
               for (int j = 0; j < 4; j++)
                  if (bus.mem_be_o[j]) mem[bus.mem_addr_o[13:2]][8*j +: 8] = bus.mem_wdata_o[8*j +: 8];
            end else rdq = mem[bus.mem_addr_o[13:2]];
         end
      end
   end

   function automatic int count_we(input logic we);
      int n = 0;
      foreach (log_q[i]) if (log_q[i].we == we) n++;
      return n;
   endfunction

   task automatic step();
      @(posedge ACLK); #1;
   endtask

   // Trigger a copy, measure busy duration, then check flags, word count and memory image
   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sz,
                          input logic en, input bit disturb);
      int bcyc, nw, exp_busy;
      logic [31:0] sa, da, a, b;
      clr_int = 1'b1; step(); clr_int = 1'b0;
      chk("clr_pending", int_pending, 1'b0);
      snap = mem;
      log_q.delete();
      src_addr = s; dst_addr = d; size = sz; int_en = en; trigger = 1'b1;
      step(); trigger = 1'b0;
      chk("first_req", bus.mem_req_o, sz != 16'd0);
      bcyc = 0;
      while (busy && bcyc < 5000) begin
         if (disturb && bcyc == 6) begin
            trigger = 1'b1; src_addr = 32'h3000; dst_addr = 32'h3800; size = 16'd4;
         end else trigger = 1'b0;
         step();
         bcyc++;
      end
      trigger = 1'b0;
      nw = (int'(sz) + 3) / 4;
      exp_busy = (sz == 16'd0) ? 1 : nw * (4 + 2*gdly + 2*rdly) + 1;
      chk("busy_cycles", bcyc, exp_busy);
      chk("pending_set", int_pending, 1'b1);
      chk("int_o", int_irq, en);
      chk("reads", count_we(1'b0), nw);
      chk("writes", count_we(1'b1), nw);
      sa = s & ~32'd3;
      da = d & ~32'd3;
      expm = snap;
      for (int i = 0; i < int'(sz); i++) begin
         a = sa + i; b = da + i;
         expm[b[13:2]][8*b[1:0] +: 8] = snap[a[13:2]][8*a[1:0] +: 8];
      end
      for (int k = 0; k <= nw; k++) begin
         b = da + 32'(4*k);
         chk($sformatf("dst_word[%0d]", k), mem[b[13:2]], expm[b[13:2]]);
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      for (int k = 0; k < 4; k++) mem[12'h400 + k] = 32'h11111111 * (k + 1);

      // reset state
      repeat (3) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_pending", int_pending, 1'b0);
      chk("rst_int", int_irq, 1'b0);
      chk("rst_req", bus.mem_req_o, 1'b0);
      chk("rst_addr", bus.mem_addr_o, 32'h0);
      chk("rst_be", bus.mem_be_o, 4'h0);
      chk("rst_wdata", bus.mem_wdata_o, 32'h0);
      ARESET = 1'b0;
      step();

      // zero-wait 16-byte copy with interleaved R/W order
      do_copy(32'h1000, 32'h2000, 16'd16, 1'b1, 1'b0);
      chk("t1_log_len", log_q.size(), 8);
      if (log_q.size() == 8)
         for (int k = 0; k < 4; k++) begin
            chk("t1_rd_we",   log_q[2*k].we,     1'b0);
            chk("t1_rd_addr", log_q[2*k].addr,   32'h1000 + 4*k);
            chk("t1_wr_we",   log_q[2*k+1].we,   1'b1);
            chk("t1_wr_addr", log_q[2*k+1].addr, 32'h2000 + 4*k);
            chk("t1_wr_be",   log_q[2*k+1].be,   4'hF);
            chk("t1_wr_data", log_q[2*k+1].data, 32'h11111111 * (k + 1));
         end

      // unaligned addresses with a 2-byte tail
      do_copy(32'h1003, 32'h2002, 16'd6, 1'b1, 1'b0);
      chk("t2_log_len", log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk("t2_rd0", log_q[0].addr, 32'h1000);
         chk("t2_rd1", log_q[2].addr, 32'h1004);
         chk("t2_wr0", log_q[1].addr, 32'h2000);
         chk("t2_be0", log_q[1].be, 4'hF);
         chk("t2_wr1", log_q[3].addr, 32'h2004);
         chk("t2_be1", log_q[3].be, 4'b0011);
      end

      // size 0 with interrupt disabled
      do_copy(32'h1000, 32'h2400, 16'd0, 1'b0, 1'b0);
      chk("t3_no_req", log_q.size(), 0);

      // destination wraps past the top of the address space
      do_copy(32'h1300, 32'hFFFF_FFFA, 16'd10, 1'b1, 1'b0);
      if (log_q.size() == 6) chk("wrap_last_addr", log_q[5].addr, 32'h0);

      // stalled gnt/rvalid with a stray trigger mid-copy
      gdly = 3; rdly = 2;
      do_copy(32'h1500, 32'h2500, 16'd20, 1'b1, 1'b1);
      gdly = 0; rdly = 0;

      // clear colliding with DONE: set wins, clear one cycle later takes effect
      clr_int = 1'b1; step(); clr_int = 1'b0;
      src_addr = 32'h1100; dst_addr = 32'h2100; size = 16'd4; int_en = 1'b1; trigger = 1'b1;
      step(); trigger = 1'b0;
      repeat (4) step();
      chk("t5_busy_in_done", busy, 1'b1);
      chk("t5_pend_before", int_pending, 1'b0);
      clr_int = 1'b1; step();
      chk("t5_set_wins", int_pending, 1'b1);
      chk("t5_int_o", int_irq, 1'b1);
      chk("t5_idle", busy, 1'b0);
      step(); clr_int = 1'b0;
      chk("t5_cleared", int_pending, 1'b0);

      // reset during WR_WAIT of word 2 of 4
      rdly = 3;
      log_q.delete();
      src_addr = 32'h1200; dst_addr = 32'h2200; size = 16'd16; trigger = 1'b1;
      step(); trigger = 1'b0;
      n = 0;
      while (count_we(1'b1) < 2 && n < 200) begin step(); n++; end
      chk("t6_reached_wr2", count_we(1'b1), 2);
      ARESET = 1'b1; step();
      chk("t6_busy", busy, 1'b0);
      chk("t6_req", bus.mem_req_o, 1'b0);
      chk("t6_addr", bus.mem_addr_o, 32'h0);
      chk("t6_be", bus.mem_be_o, 4'h0);
      chk("t6_wdata", bus.mem_wdata_o, 32'h0);
      chk("t6_pending", int_pending, 1'b0);
      ARESET = 1'b0; rdly = 0; stray = 1'b1; step(); stray = 1'b0;
      chk("t6_stray_busy", busy, 1'b0);
      chk("t6_stray_req", bus.mem_req_o, 1'b0);
      step();
      chk("t6_still_idle", busy, 1'b0);
      do_copy(32'h1200, 32'h2200, 16'd16, 1'b1, 1'b0);

      // randomized copies
      for (int r = 0; r < 5; r++) begin
         gdly = $urandom_range(0, 2);
         rdly = $urandom_range(0, 2);
         do_copy($urandom_range(0, 32'hF00), 32'h2000 + $urandom_range(0, 32'hF00),
                 16'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule
